// File: rtl/csr_file.sv
// Machine-mode CSR file: trap CSRs, 64-bit mcycle/minstret counters,
// single-cycle read-modify-write access and trap/mret PC redirect.
module csr_file #(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  MTVEC_RESET = 32'h0000_0000,
  parameter logic [XLEN-1:0]  HART_ID     = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_write_enable,
  input  logic [2:0]      csr_func3,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_rs1_data,
  input  logic [4:0]      csr_uimm,
  output logic [XLEN-1:0] csr_read_data,
  output logic            illegal_csr,
  input  logic            instr_retired,
  input  logic            take_trap,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_target,
  output logic            irq_enable
);

  logic            mie;
  logic            mpie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [63:0]     mcycle;
  logic [63:0]     minstret;

  logic            known;
  logic            read_only;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] wdata;
  logic            op_writes;
  logic            do_write;

  // Address decode and current value of the selected CSR
  always_comb begin
    known   = 1'b1;
    old_val = 32'h0000_0000;
    case (csr_addr)
      12'h300: old_val = {24'h00_0000, mpie, 3'b000, mie, 3'b000};
      12'h305: old_val = mtvec;
      12'h340: old_val = mscratch;
      12'h341: old_val = mepc;
      12'h342: old_val = mcause;
      12'hB00: old_val = mcycle[31:0];
      12'hB80: old_val = mcycle[63:32];
      12'hB02: old_val = minstret[31:0];
      12'hB82: old_val = minstret[63:32];
      12'hF14: old_val = HART_ID;
      default: begin
        known   = 1'b0;
        old_val = 32'h0000_0000;
      end
    endcase
  end

  assign read_only = (csr_addr[11:10] == 2'b11);
  assign operand   = csr_func3[2] ? {27'h000_0000, csr_uimm} : csr_rs1_data;

  // Read-modify-write value; RS/RC with a zero operand leave the CSR untouched
  always_comb begin
    wdata     = old_val;
    op_writes = 1'b0;
    case (csr_func3[1:0])
      2'b01: begin
        wdata     = operand;
        op_writes = 1'b1;
      end
      2'b10: begin
        wdata     = old_val | operand;
        op_writes = (operand != 32'h0000_0000);
      end
      2'b11: begin
        wdata     = old_val & ~operand;
        op_writes = (operand != 32'h0000_0000);
      end
      default: begin
        wdata     = old_val;
        op_writes = 1'b0;
      end
    endcase
  end

  assign illegal_csr   = csr_write_enable & (~known | read_only);
  assign csr_read_data = illegal_csr ? 32'h0000_0000 : old_val;
  assign do_write      = csr_write_enable & ~illegal_csr & op_writes & ~take_trap & ~mret;

  assign trap_redirect = take_trap | mret;
  assign trap_target   = take_trap ? mtvec : (mret ? mepc : 32'h0000_0000);
  assign irq_enable    = mie;

  // Trap CSRs: trap beats mret beats a CSR write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET & 32'hFFFF_FFFC;
      mscratch <= 32'h0000_0000;
      mepc     <= 32'h0000_0000;
      mcause   <= 32'h0000_0000;
    end else if (take_trap) begin
      mepc   <= trap_pc & 32'hFFFF_FFFC;
      mcause <= trap_cause;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (mret) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (do_write) begin
      case (csr_addr)
        12'h300: begin
          mie  <= wdata[3];
          mpie <= wdata[7];
        end
        12'h305: mtvec    <= wdata & 32'hFFFF_FFFC;
        12'h340: mscratch <= wdata;
        12'h341: mepc     <= wdata & 32'hFFFF_FFFC;
        12'h342: mcause   <= wdata;
        default: ;
      endcase
    end
  end

  // Counters: a write to either half freezes the other half for that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= 64'h0;
      minstret <= 64'h0;
    end else begin
      if (do_write && csr_addr == 12'hB00) begin
        mcycle <= {mcycle[63:32], wdata};
      end else if (do_write && csr_addr == 12'hB80) begin
        mcycle <= {wdata, mcycle[31:0]};
      end else begin
        mcycle <= mcycle + 64'd1;
      end

      if (do_write && csr_addr == 12'hB02) begin
        minstret <= {minstret[63:32], wdata};
      end else if (do_write && csr_addr == 12'hB82) begin
        minstret <= {wdata, minstret[31:0]};
      end else if (instr_retired && !take_trap) begin
        minstret <= minstret + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file with hand-computed expectations.
module tb_csr_file;

  logic        clk;
  logic        rst_n;
  logic        csr_write_enable;
  logic [2:0]  csr_func3;
  logic [11:0] csr_addr;
  logic [31:0] csr_rs1_data;
  logic [4:0]  csr_uimm;
  logic [31:0] csr_read_data;
  logic        illegal_csr;
  logic        instr_retired;
  logic        take_trap;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret;
  logic        trap_redirect;
  logic [31:0] trap_target;
  logic        irq_enable;

  int n_total;
  int n_bad;
  logic [31:0] v;
  logic [31:0] w;

  csr_file #(
    .XLEN(32),
    .MTVEC_RESET(32'h0000_1003),
    .HART_ID(32'h0000_0003)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_write_enable(csr_write_enable), .csr_func3(csr_func3),
    .csr_addr(csr_addr), .csr_rs1_data(csr_rs1_data), .csr_uimm(csr_uimm),
    .csr_read_data(csr_read_data), .illegal_csr(illegal_csr),
    .instr_retired(instr_retired), .take_trap(take_trap),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .mret(mret),
    .trap_redirect(trap_redirect), .trap_target(trap_target),
    .irq_enable(irq_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] addr, output logic [31:0] data);
    csr_write_enable = 1'b0;
    csr_addr = addr;
    #1;
    data = csr_read_data;
  endtask

  task automatic set_op(input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [4:0] uimm);
    csr_write_enable = 1'b1;
    csr_func3 = f3;
    csr_addr = addr;
    csr_rs1_data = rs1;
    csr_uimm = uimm;
    #1;
  endtask

  task automatic idle();
    csr_write_enable = 1'b0;
    csr_func3 = 3'b000;
    csr_rs1_data = 32'h0;
    csr_uimm = 5'd0;
    take_trap = 1'b0;
    mret = 1'b0;
    instr_retired = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    rst_n = 1'b0;
    csr_addr = 12'h000;
    trap_cause = 32'h0;
    trap_pc = 32'h0;
    idle();
    #22;
    rst_n = 1'b1;
    step();

    // Reset state
    check_eq("rst_irq", {63'd0, irq_enable}, 64'd0);
    check_eq("rst_redir", {63'd0, trap_redirect}, 64'd0);
    check_eq("rst_target", {32'd0, trap_target}, 64'd0);
    rd(12'h300, v); check_eq("rst_mstatus", {32'd0, v}, 64'h0);
    rd(12'h305, v); check_eq("rst_mtvec", {32'd0, v}, 64'h1000);
    rd(12'hB00, v); check_eq("rst_mcycle_small", {63'd0, (v <= 32'd10)}, 64'd1);
    rd(12'hB02, v); check_eq("rst_minstret", {32'd0, v}, 64'h0);

    // CSRRW / CSRRC / CSRRSI on mscratch
    set_op(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd0);
    check_eq("rw_old", {32'd0, csr_read_data}, 64'h0);
    check_eq("rw_legal", {63'd0, illegal_csr}, 64'd0);
    step(); idle();
    rd(12'h340, v); check_eq("rw_new", {32'd0, v}, 64'hDEAD_BEEF);
    set_op(3'b011, 12'h340, 32'h0000_00FF, 5'd0);
    check_eq("rc_old", {32'd0, csr_read_data}, 64'hDEAD_BEEF);
    step(); idle();
    rd(12'h340, v); check_eq("rc_new", {32'd0, v}, 64'hDEAD_BE00);
    set_op(3'b110, 12'h340, 32'hFFFF_FFFF, 5'd3);
    step(); idle();
    rd(12'h340, v); check_eq("rsi_new", {32'd0, v}, 64'hDEAD_BE03);
    set_op(3'b111, 12'h340, 32'h0, 5'd0);
    step(); idle();
    rd(12'h340, v); check_eq("rci_zero_nowrite", {32'd0, v}, 64'hDEAD_BE03);
    set_op(3'b001, 12'h341, 32'h0000_0207, 5'd0);
    step(); idle();
    rd(12'h341, v); check_eq("mepc_align", {32'd0, v}, 64'h204);

    // Trap then mret
    set_op(3'b001, 12'h300, 32'hFFFF_FFFF, 5'd0);
    step(); idle();
    rd(12'h300, v); check_eq("mstatus_mask", {32'd0, v}, 64'h88);
    set_op(3'b001, 12'h300, 32'h0000_0008, 5'd0);
    step(); idle();
    rd(12'h300, v); check_eq("mstatus_mie", {32'd0, v}, 64'h8);
    check_eq("irq_on", {63'd0, irq_enable}, 64'd1);
    take_trap = 1'b1; trap_cause = 32'd2; trap_pc = 32'h0000_0104;
    #1;
    check_eq("trap_redir", {63'd0, trap_redirect}, 64'd1);
    check_eq("trap_target", {32'd0, trap_target}, 64'h1000);
    step(); idle();
    rd(12'h341, v); check_eq("trap_mepc", {32'd0, v}, 64'h104);
    rd(12'h342, v); check_eq("trap_mcause", {32'd0, v}, 64'h2);
    rd(12'h300, v); check_eq("trap_mstatus", {32'd0, v}, 64'h80);
    check_eq("trap_irq_off", {63'd0, irq_enable}, 64'd0);
    mret = 1'b1;
    #1;
    check_eq("mret_redir", {63'd0, trap_redirect}, 64'd1);
    check_eq("mret_target", {32'd0, trap_target}, 64'h104);
    step(); idle();
    #1;
    rd(12'h300, v); check_eq("mret_mstatus", {32'd0, v}, 64'h88);
    check_eq("mret_irq", {63'd0, irq_enable}, 64'd1);
    check_eq("idle_redir", {63'd0, trap_redirect}, 64'd0);
    check_eq("idle_target", {32'd0, trap_target}, 64'd0);

    // 64-bit cycle counter wrap
    set_op(3'b001, 12'hB80, 32'hFFFF_FFFF, 5'd0);
    step();
    set_op(3'b001, 12'hB00, 32'hFFFF_FFFE, 5'd0);
    step(); idle();
    rd(12'hB00, v); rd(12'hB80, w);
    check_eq("wrap_written", {w, v}, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    rd(12'hB00, v); rd(12'hB80, w);
    check_eq("wrap_max", {w, v}, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    rd(12'hB00, v); rd(12'hB80, w);
    check_eq("wrap_zero", {w, v}, 64'h0);

    // Illegal accesses
    set_op(3'b001, 12'hF14, 32'h0000_1234, 5'd0);
    check_eq("ro_illegal", {63'd0, illegal_csr}, 64'd1);
    check_eq("ro_rdata0", {32'd0, csr_read_data}, 64'd0);
    step(); idle();
    rd(12'hF14, v); check_eq("hartid", {32'd0, v}, 64'h3);
    check_eq("ro_read_legal", {63'd0, illegal_csr}, 64'd0);
    set_op(3'b001, 12'h7C0, 32'h0000_1234, 5'd0);
    check_eq("unk_illegal", {63'd0, illegal_csr}, 64'd1);
    check_eq("unk_rdata0", {32'd0, csr_read_data}, 64'd0);
    set_op(3'b001, 12'h340, 32'h0000_1234, 5'd0);
    check_eq("legal_again", {63'd0, illegal_csr}, 64'd0);
    set_op(3'b010, 12'hF14, 32'h0, 5'd0);
    check_eq("ro_rs_zero_illegal", {63'd0, illegal_csr}, 64'd1);
    idle();
    rd(12'h340, v); check_eq("illegal_nowrite", {32'd0, v}, 64'hDEAD_BE03);

    // minstret and trap/write collision
    instr_retired = 1'b1;
    step(); step(); step();
    idle();
    rd(12'hB02, v); check_eq("minstret_3", {32'd0, v}, 64'd3);
    set_op(3'b001, 12'h305, 32'h0000_2000, 5'd0);
    take_trap = 1'b1; mret = 1'b1; instr_retired = 1'b1;
    trap_cause = 32'd7; trap_pc = 32'h0000_0300;
    #1;
    check_eq("coll_target", {32'd0, trap_target}, 64'h1000);
    step(); idle();
    rd(12'h305, v); check_eq("coll_mtvec", {32'd0, v}, 64'h1000);
    rd(12'hB02, v); check_eq("coll_minstret", {32'd0, v}, 64'd3);
    rd(12'h342, v); check_eq("coll_mcause", {32'd0, v}, 64'd7);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
